// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: first-word-fall-through read port,
// registered fill level with threshold flag, and sticky overrun/underflow flags.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int THRESH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic              thresh_irq,
    output logic              overrun,
    output logic              underflow,
    input  logic              clr,
    input  logic              err_clr
);

    localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   THRESH_L = (ADDR_W + 1)'(THRESH);
    localparam logic [ADDR_W:0]   LVL_ONE  = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level_next;
    logic              push_ok;
    logic              pop_ok;
    logic              overrun_ev;
    logic              underflow_ev;

    assign empty = (level == '0);
    assign full  = (level == DEPTH);

    // A push into a full FIFO is still accepted when the head is popped in the same cycle.
    assign pop_ok       = rd_en && !empty;
    assign push_ok      = wr_en && (!full || rd_en);
    assign overrun_ev   = wr_en && !push_ok;
    assign underflow_ev = rd_en && empty;

    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_comb begin
        level_next = level;
        if (push_ok && !pop_ok)
            level_next = level + LVL_ONE;
        else if (pop_ok && !push_ok)
            level_next = level - LVL_ONE;
    end

    // NOTE: storage has no reset; only pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok && !clr)
            mem[wr_ptr] <= wr_data;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            thresh_irq <= 1'b0;
            overrun    <= 1'b0;
            underflow  <= 1'b0;
        end else if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            thresh_irq <= 1'b0;
            overrun    <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)
                rd_ptr <= rd_ptr + PTR_ONE;
            level      <= level_next;
            thresh_irq <= (level_next >= THRESH_L);
            // A new error event in the same cycle as err_clr leaves the flag set.
            if (overrun_ev)
                overrun <= 1'b1;
            else if (err_clr)
                overrun <= 1'b0;
            if (underflow_ev)
                underflow <= 1'b1;
            else if (err_clr)
                underflow <= 1'b0;
        end
    end

endmodule
